axi_dma_lite_cfg_seq: RTL and testbench

AXI_DMA_LITE_CFG_SEQ -- requirements
Module: axi_dma_lite_cfg_seq

---
 rtl/axi_dma_lite_cfg_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_axi_dma_lite_cfg_seq.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_dma_lite_cfg_seq.sv
// axi_dma_lite_cfg_seq
// Drives one MM2S transfer on an AXI DMA through an AXI-Lite master port.
// The sequence is: write the control register (run + IOC interrupt enable),
// write the source address, write the length, then poll the status register
// until IOC is set. IOC is then cleared (write-1-to-clear) and done pulses.
// Any bad bus response, a zero length or a DMA error bit ends in the ERR
// state, which sets the sticky error flag.
//
// Optional feature: define CFG_SEQ_TIMEOUT_EN to bound the number of status
// polls to POLL_MAX. Without it the sequencer polls indefinitely.
//
// Ports
//   axi_aclk, axi_reset      clock, synchronous active-high reset
//   start, src_addr, xfer_len transfer request (sampled when accepted in IDLE)
//   busy, done, error        progress, one-cycle completion, sticky failure
//   status                   last status register value read
//   m_axi_lite_*             AXI-Lite master (AW, W, B, AR, R channels)
module axi_dma_lite_cfg_seq #(
  parameter int ADDR_W   = 10,
  parameter int POLL_MAX = 1024
) (
  input  logic              axi_aclk,
  input  logic              axi_reset,
  input  logic              start,
  input  logic [31:0]       src_addr,
  input  logic [25:0]       xfer_len,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       status,
  output logic              m_axi_lite_awvalid,
  input  logic              m_axi_lite_awready,
  output logic [ADDR_W-1:0] m_axi_lite_awaddr,
  output logic              m_axi_lite_wvalid,
  input  logic              m_axi_lite_wready,
  output logic [31:0]       m_axi_lite_wdata,
  input  logic              m_axi_lite_bvalid,
  output logic              m_axi_lite_bready,
  input  logic [1:0]        m_axi_lite_bresp,
  output logic              m_axi_lite_arvalid,
  input  logic              m_axi_lite_arready,
  output logic [ADDR_W-1:0] m_axi_lite_araddr,
  input  logic              m_axi_lite_rvalid,
  output logic              m_axi_lite_rready,
  input  logic [31:0]       m_axi_lite_rdata,
  input  logic [1:0]        m_axi_lite_rresp
);

  localparam logic [ADDR_W-1:0] REG_CR  = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] REG_SR  = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] REG_SA  = ADDR_W'(32'h18);
  localparam logic [ADDR_W-1:0] REG_LEN = ADDR_W'(32'h28);
  localparam logic [31:0] CR_RUN_IOC = 32'h0000_1001;
  localparam logic [31:0] SR_IOC     = 32'h0000_1000;

  typedef enum logic [2:0] {
    IDLE, WR_CR, WR_SA, WR_LEN, RD_SR, WR_CLR, DONE, ERR
  } state_t;

  state_t      state_reg, state_next;
  logic        aw_done_reg, aw_done_next;  // AW handshake finished for current write
  logic        w_done_reg, w_done_next;    // W handshake finished for current write
  logic        ar_done_reg, ar_done_next;  // AR handshake finished, waiting for R
  logic        gap_reg, gap_next;          // idle cycle between status polls
  logic        error_reg, error_next;
  logic [31:0] src_reg, src_next;
  logic [25:0] len_reg, len_next;
  logic [31:0] status_reg, status_next;

  // Per-state write target and successor; only meaningful in write states.
  logic              is_write;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  state_t            wr_follow;

`ifdef CFG_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(POLL_MAX + 1);
  logic [CNT_W-1:0] poll_cnt_reg, poll_cnt_next;
  logic             poll_timeout;
  // The read completing now is the POLL_MAX-th since WR_CR was entered.
  assign poll_timeout = (poll_cnt_reg == CNT_W'(POLL_MAX - 1));
`endif

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state_reg    <= IDLE;
      aw_done_reg  <= 1'b0;
      w_done_reg   <= 1'b0;
      ar_done_reg  <= 1'b0;
      gap_reg      <= 1'b0;
      error_reg    <= 1'b0;
      src_reg      <= '0;
      len_reg      <= '0;
      status_reg   <= '0;
`ifdef CFG_SEQ_TIMEOUT_EN
      poll_cnt_reg <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      aw_done_reg  <= aw_done_next;
      w_done_reg   <= w_done_next;
      ar_done_reg  <= ar_done_next;
      gap_reg      <= gap_next;
      error_reg    <= error_next;
      src_reg      <= src_next;
      len_reg      <= len_next;
      status_reg   <= status_next;
`ifdef CFG_SEQ_TIMEOUT_EN
      poll_cnt_reg <= poll_cnt_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    ar_done_next = ar_done_reg;
    gap_next     = gap_reg;
    error_next   = error_reg;
    src_next     = src_reg;
    len_next     = len_reg;
    status_next  = status_reg;
`ifdef CFG_SEQ_TIMEOUT_EN
    poll_cnt_next = poll_cnt_reg;
`endif
    m_axi_lite_awvalid = 1'b0;
    m_axi_lite_awaddr  = '0;
    m_axi_lite_wvalid  = 1'b0;
    m_axi_lite_wdata   = '0;
    m_axi_lite_bready  = 1'b0;
    m_axi_lite_arvalid = 1'b0;
    m_axi_lite_araddr  = '0;
    m_axi_lite_rready  = 1'b0;
    done               = 1'b0;
    is_write           = 1'b1;
    wr_addr            = '0;
    wr_data            = '0;
    wr_follow          = IDLE;

    case (state_reg)
      WR_CR:  begin wr_addr = REG_CR;  wr_data = CR_RUN_IOC;        wr_follow = WR_SA;  end
      WR_SA:  begin wr_addr = REG_SA;  wr_data = src_reg;           wr_follow = WR_LEN; end
      WR_LEN: begin wr_addr = REG_LEN; wr_data = {6'b0, len_reg};   wr_follow = RD_SR;  end
      WR_CLR: begin wr_addr = REG_SR;  wr_data = SR_IOC;            wr_follow = DONE;   end
      default: is_write = 1'b0;
    endcase

    // Shared write engine: AW and W are offered together and retire
    // independently; B is accepted only once both have been taken.
    if (is_write) begin
      m_axi_lite_awvalid = !aw_done_reg;
      m_axi_lite_wvalid  = !w_done_reg;
      m_axi_lite_awaddr  = wr_addr;
      m_axi_lite_wdata   = wr_data;
      m_axi_lite_bready  = aw_done_reg && w_done_reg;
      if (m_axi_lite_awvalid && m_axi_lite_awready) aw_done_next = 1'b1;
      if (m_axi_lite_wvalid && m_axi_lite_wready)   w_done_next  = 1'b1;
      if (m_axi_lite_bready && m_axi_lite_bvalid) begin
        aw_done_next = 1'b0;
        w_done_next  = 1'b0;
        state_next   = (m_axi_lite_bresp != 2'b00) ? ERR : wr_follow;
      end
    end

    case (state_reg)
      IDLE: begin
        if (start) begin
          src_next   = src_addr;
          len_next   = xfer_len;
          error_next = 1'b0;
          gap_next   = 1'b0;
`ifdef CFG_SEQ_TIMEOUT_EN
          poll_cnt_next = '0;
`endif
          state_next = (xfer_len == 26'd0) ? ERR : WR_CR;
        end
      end
      RD_SR: begin
        m_axi_lite_araddr = REG_SR;
        if (gap_reg) begin
          gap_next = 1'b0;
        end else if (!ar_done_reg) begin
          m_axi_lite_arvalid = 1'b1;
          if (m_axi_lite_arready) ar_done_next = 1'b1;
        end else begin
          m_axi_lite_rready = 1'b1;
          if (m_axi_lite_rvalid) begin
            status_next  = m_axi_lite_rdata;
            ar_done_next = 1'b0;
`ifdef CFG_SEQ_TIMEOUT_EN
            poll_cnt_next = poll_cnt_reg + 1'b1;
`endif
            // DMA error bits take priority over IOC.
            if (m_axi_lite_rresp != 2'b00 || m_axi_lite_rdata[6:4] != 3'b000)
              state_next = ERR;
            else if (m_axi_lite_rdata[12])
              state_next = WR_CLR;
`ifdef CFG_SEQ_TIMEOUT_EN
            else if (poll_timeout)
              state_next = ERR;
`endif
            else
              gap_next = 1'b1;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      ERR: state_next = IDLE;
      default: ;
    endcase

    // error rises on the edge that enters ERR and holds until the next start.
    if (state_next == ERR) error_next = 1'b1;
  end

  assign busy   = (state_reg != IDLE);
  assign error  = error_reg;
  assign status = status_reg;

endmodule

// File: tb/tb_axi_dma_lite_cfg_seq.sv
// Testbench for axi_dma_lite_cfg_seq: an AXI-Lite slave with configurable
// ready delays, bresp injection and a scripted status-register sequence,
// checked against a transfer-level reference model.
module tb_axi_dma_lite_cfg_seq;
  localparam int ADDR_W      = 10;
  localparam int TB_POLL_MAX = 8;
`ifdef CFG_SEQ_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              axi_reset = 1'b1;
  logic              start = 1'b0;
  logic [31:0]       src_addr = '0;
  logic [25:0]       xfer_len = '0;
  logic              busy, done, error;
  logic [31:0]       status;
  logic              awvalid, wvalid, bready, arvalid, rready;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [31:0]       wdata;
  logic              awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]        bresp = 2'b00, rresp = 2'b00;
  logic [31:0]       rdata = '0;

  always #5 clk = ~clk;

  axi_dma_lite_cfg_seq #(.ADDR_W(ADDR_W), .POLL_MAX(TB_POLL_MAX)) dut (
    .axi_aclk(clk), .axi_reset(axi_reset), .start(start), .src_addr(src_addr),
    .xfer_len(xfer_len), .busy(busy), .done(done), .error(error), .status(status),
    .m_axi_lite_awvalid(awvalid), .m_axi_lite_awready(awready), .m_axi_lite_awaddr(awaddr),
    .m_axi_lite_wvalid(wvalid), .m_axi_lite_wready(wready), .m_axi_lite_wdata(wdata),
    .m_axi_lite_bvalid(bvalid), .m_axi_lite_bready(bready), .m_axi_lite_bresp(bresp),
    .m_axi_lite_arvalid(arvalid), .m_axi_lite_arready(arready), .m_axi_lite_araddr(araddr),
    .m_axi_lite_rvalid(rvalid), .m_axi_lite_rready(rready), .m_axi_lite_rdata(rdata),
    .m_axi_lite_rresp(rresp)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Slave configuration and observation
  int          aw_delay = 0, w_delay = 0, bresp_fail_idx = -1;
  int          aw_cyc = 0, w_cyc = 0, b_idx = 0, rd_cnt = 0, done_cnt = 0;
  bit          aw_ever = 0, ar_ever = 0;
  logic [31:0] cap_addr = '0, cap_data = '0, sr_default = 32'h1000;
  logic [31:0] sr_q[$], exp_sr[$], wr_addr_q[$], wr_data_q[$];
  int          aw_cyc_q[$], w_cyc_q[$];

  // Reference model outputs
  logic [31:0] exp_addr_q[$], exp_data_q[$];
  logic [31:0] exp_status = '0;
  int          exp_reads = 0, exp_done = 0;
  bit          exp_err = 0;

  // Slave: inputs for the coming rising edge are decided on the falling edge.
  always @(negedge clk) begin
    if (awvalid) begin
      aw_cyc++;
      aw_ever = 1;
      awready = (aw_cyc > aw_delay);
      if (awready) cap_addr = 32'(awaddr);
    end else awready = 1'b0;
    if (wvalid) begin
      w_cyc++;
      wready = (w_cyc > w_delay);
      if (wready) cap_data = wdata;
    end else wready = 1'b0;
    if (bready) begin
      bvalid = 1'b1;
      bresp  = (b_idx == bresp_fail_idx) ? 2'b10 : 2'b00;
      wr_addr_q.push_back(cap_addr);
      wr_data_q.push_back(cap_data);
      aw_cyc_q.push_back(aw_cyc);
      w_cyc_q.push_back(w_cyc);
      aw_cyc = 0;
      w_cyc  = 0;
      b_idx++;
    end else begin
      bvalid = 1'b0;
      bresp  = 2'b00;
    end
    arready = arvalid;
    if (arvalid) ar_ever = 1;
    if (rready) begin
      rvalid = 1'b1;
      rdata  = (sr_q.size() > 0) ? sr_q.pop_front() : sr_default;
      rresp  = 2'b00;
      rd_cnt++;
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
    end
    if (done) done_cnt++;
  end

  // Transfer-level model: the register writes, poll count and outcome that
  // one start should produce given the slave's scripted behaviour.
  task automatic model_run(input logic [31:0] src, input logic [25:0] len, input int fail_idx);
    logic [31:0] cfg_addr[3];
    logic [31:0] cfg_data[3];
    logic [31:0] v;
    int n;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_reads = 0;
    exp_done  = 0;
    exp_err   = 0;
    if (len == 26'd0) begin exp_err = 1; return; end
    cfg_addr = '{32'h00, 32'h18, 32'h28};
    cfg_data = '{32'h1001, src, {6'b0, len}};
    for (int i = 0; i < 3; i++) begin
      exp_addr_q.push_back(cfg_addr[i]);
      exp_data_q.push_back(cfg_data[i]);
      if (i == fail_idx) begin exp_err = 1; return; end
    end
    n = 0;
    while (n < 5000) begin
      v = (exp_sr.size() > 0) ? exp_sr.pop_front() : sr_default;
      n++;
      exp_reads  = n;
      exp_status = v;
      if (v[6:4] != 3'b000) begin exp_err = 1; return; end
      if (v[12]) begin
        exp_addr_q.push_back(32'h04);
        exp_data_q.push_back(32'h1000);
        if (fail_idx == 3) exp_err = 1; else exp_done = 1;
        return;
      end
      if (TIMEOUT_EN && n == TB_POLL_MAX) begin exp_err = 1; return; end
    end
  endtask

  task automatic run_xfer(input string name, input logic [31:0] src, input logic [25:0] len,
                          input bit restart);
    bit finished = 0;
    int nw;
    exp_sr = sr_q;
    model_run(src, len, bresp_fail_idx);
    wr_addr_q.delete(); wr_data_q.delete(); aw_cyc_q.delete(); w_cyc_q.delete();
    b_idx = 0; rd_cnt = 0; done_cnt = 0; aw_ever = 0; ar_ever = 0; aw_cyc = 0; w_cyc = 0;
    @(negedge clk); #1;
    start = 1'b1; src_addr = src; xfer_len = len;
    @(negedge clk); #1;
    start = 1'b0; src_addr = $urandom; xfer_len = 26'($urandom);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (restart && cyc == 2) begin start = 1'b1; xfer_len = 26'd1; end
      if (restart && cyc == 3) start = 1'b0;
      if (!busy) begin finished = 1; break; end
      @(negedge clk); #1;
    end
    n_checks++;
    if (!finished) begin n_fail++; $display("FAIL %s completion: busy=%b required 0 within budget", name, busy); end
    n_checks++;
    if (wr_addr_q.size() !== exp_addr_q.size()) begin
      n_fail++; $display("FAIL %s write_count: got %0d required %0d", name, wr_addr_q.size(), exp_addr_q.size());
    end
    nw = (wr_addr_q.size() < exp_addr_q.size()) ? wr_addr_q.size() : exp_addr_q.size();
    for (int i = 0; i < nw; i++) begin
      n_checks++;
      if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
        n_fail++;
        $display("FAIL %s write%0d: got %h/%h required %h/%h", name, i, wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
      end
    end
    n_checks++;
    if (rd_cnt !== exp_reads) begin n_fail++; $display("FAIL %s reads: got %0d required %0d", name, rd_cnt, exp_reads); end
    n_checks++;
    if (status !== exp_status) begin n_fail++; $display("FAIL %s status: got %h required %h", name, status, exp_status); end
    n_checks++;
    if (error !== exp_err) begin n_fail++; $display("FAIL %s error: got %b required %b", name, error, exp_err); end
    n_checks++;
    if (done_cnt !== exp_done) begin n_fail++; $display("FAIL %s done_pulses: got %0d required %0d", name, done_cnt, exp_done); end
    $display("xfer %s src=%h len=%0d writes=%0d reads=%0d status=%h err=%b done=%0d",
             name, src, len, wr_addr_q.size(), rd_cnt, status, error, done_cnt);
    sr_q.delete();
  endtask

  task automatic test_reset();
    axi_reset = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({busy, done, error} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b required 000", {busy, done, error}); end
    n_checks++;
    if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
      n_fail++; $display("FAIL reset_handshakes: got %b required 00000", {awvalid, wvalid, bready, arvalid, rready});
    end
    n_checks++;
    if (status !== 32'h0 || wdata !== 32'h0 || awaddr !== '0 || araddr !== '0) begin
      n_fail++; $display("FAIL reset_data: got status=%h wdata=%h awaddr=%h araddr=%h required all 0", status, wdata, awaddr, araddr);
    end
    start = 1'b0;
    axi_reset = 1'b0;
    exp_status = '0;
    $display("reset checked");
  endtask

  task automatic test_basic();
    sr_q = '{32'h1000};
    run_xfer("basic", 32'h1000, 26'd64, 0);
    n_checks++;
    if (aw_cyc_q.size() < 1 || aw_cyc_q[0] !== 1 || w_cyc_q[0] !== 1) begin
      n_fail++; $display("FAIL basic_zero_wait: first write aw/w cycles not 1/1 (writes=%0d)", aw_cyc_q.size());
    end
  endtask

  task automatic test_zero_len();
    aw_ever = 0; ar_ever = 0;
    @(negedge clk); #1;
    start = 1'b1; xfer_len = 26'd0; src_addr = $urandom;
    @(negedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (error !== 1'b1) begin n_fail++; $display("FAIL zero_len_error: got %b required 1 one cycle after start", error); end
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || error !== 1'b1) begin n_fail++; $display("FAIL zero_len_idle: got busy=%b error=%b required 0/1", busy, error); end
    n_checks++;
    if (aw_ever || ar_ever) begin n_fail++; $display("FAIL zero_len_bus: got aw=%b ar=%b required no activity", aw_ever, ar_ever); end
    $display("xfer zero_len err=%b busy=%b", error, busy);
  endtask

  task automatic test_bresp_err();
    bresp_fail_idx = 1;
    run_xfer("bresp_sa", 32'hCAFE_0000, 26'd100, 0);
    bresp_fail_idx = -1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || error !== 1'b1) begin n_fail++; $display("FAIL bresp_sticky: got busy=%b error=%b required 0/1", busy, error); end
  endtask

  task automatic test_sr_err();
    sr_q = '{32'h0, 32'h0, 32'h0, 32'h10};
    run_xfer("sr_err", 32'h2000, 26'd32, 0);
  endtask

  task automatic test_aw_delay();
    aw_delay = 3;
    sr_q = '{32'h1000};
    run_xfer("aw_delay", 32'h3000, 26'd8, 0);
    aw_delay = 0;
    n_checks++;
    if (aw_cyc_q.size() < 1 || aw_cyc_q[0] !== 4 || w_cyc_q[0] !== 1) begin
      n_fail++;
      $display("FAIL aw_delay_valids: got aw=%0d w=%0d required 4/1",
               (aw_cyc_q.size() > 0) ? aw_cyc_q[0] : -1, (w_cyc_q.size() > 0) ? w_cyc_q[0] : -1);
    end
  endtask

  task automatic test_back_to_back();
    sr_q = '{32'h0, 32'h0, 32'h1000};
    run_xfer("b2b_restart_ignored", 32'h4444_0000, 26'd12, 1);
    sr_q = '{32'h1000};
    run_xfer("b2b_second", 32'h5555_0000, 26'd13, 0);
  endtask

  task automatic test_random();
    logic [31:0] v;
    int nz;
    for (int it = 0; it < 25; it++) begin
      nz = $urandom_range(0, 3);
      for (int k = 0; k < nz; k++) begin
        v = $urandom; v[12] = 1'b0; v[6:4] = 3'b000;
        sr_q.push_back(v);
      end
      v = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        v[12] = 1'b1;
        if ($urandom_range(0, 3) != 0) v[6:4] = 3'b000;
      end else begin
        v[6:4] = 3'($urandom_range(1, 7));
      end
      sr_q.push_back(v);
      aw_delay = $urandom_range(0, 2);
      w_delay  = $urandom_range(0, 2);
      bresp_fail_idx = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : -1;
      run_xfer($sformatf("rand%0d", it), $urandom, 26'($urandom_range(1, 67108863)), 0);
    end
    aw_delay = 0; w_delay = 0; bresp_fail_idx = -1;
  endtask

  task automatic test_reset_mid();
    bit reached = 0;
    sr_default = 32'h0;
    @(negedge clk); #1;
    start = 1'b1; src_addr = 32'h6000; xfer_len = 26'd4;
    @(negedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (rd_cnt >= 2) begin reached = 1; break; end
      @(negedge clk); #1;
    end
    rd_cnt = 0;
    n_checks++;
    if (!reached) begin n_fail++; $display("FAIL reset_mid_polling: got reads=%0d required 2", rd_cnt); end
    axi_reset = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if ({busy, awvalid, wvalid, bready, arvalid, rready, done, error} !== 8'b0 || status !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %b status=%h required all 0",
                         {busy, awvalid, wvalid, bready, arvalid, rready, done, error}, status);
    end
    axi_reset = 1'b0;
    exp_status = '0;
    sr_default = 32'h1000;
    $display("reset mid-poll checked busy=%b", busy);
    sr_q = '{32'h0, 32'h1000};
    run_xfer("after_reset", 32'h7000, 26'd256, 0);
  endtask

`ifdef CFG_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    sr_default = 32'h0;
    run_xfer("timeout", 32'h8000, 26'd16, 0);
    sr_default = 32'h1000;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_basic();
    test_bresp_err();
    test_sr_err();
    test_aw_delay();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef CFG_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
